mixed_vec_seq_checker: RTL and testbench

//  Stimulus/check stage feeding the mixed-vector connect tester's stop logic.

---
 rtl/mixed_vec_pkg.sv | 38 +++
 rtl/mixed_vec_pattern_gen.sv | 23 ++
 rtl/mixed_vec_seq_checker.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mixed_vec_seq_checker.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixed_vec_pkg.sv
// Shared types and helpers for the mixed-width vector checker: element widths,
// lane masks, the test pattern constants and the run-state encoding.
package mixed_vec_pkg;

  localparam int unsigned LANE_MAX  = 64;
  localparam int unsigned ERR_CNT_W = 16;

  localparam logic [7:0] PAT_ITER_MUL = 8'h9D;
  localparam logic [7:0] PAT_ELEM_MUL = 8'h35;
  localparam logic [7:0] PAT_OFFSET   = 8'h01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Element idx carries 8*(idx+1) meaningful bits, capped at the lane width.
  function automatic int unsigned elem_width(input int unsigned idx, input int unsigned max_w);
    int unsigned w;
    w = 8 * (idx + 1);
    return (w < max_w) ? w : max_w;
  endfunction

  function automatic logic [LANE_MAX-1:0] slot_mask(input int unsigned idx, input int unsigned max_w);
    logic [LANE_MAX-1:0] m;
    int unsigned         w;
    m = '0;
    w = elem_width(idx, max_w);
    for (int unsigned j = 0; j < LANE_MAX; j++) begin
      if (j < w) m[j] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mixed_vec_pattern_gen.sv
// Combinational iteration -> packed vector of masked pattern elements; used
// both for the outgoing vector and for the expected value of the returned one.
module mixed_vec_pattern_gen
  import mixed_vec_pkg::*;
#(
  parameter int unsigned NUM_ELEMS = 4,
  parameter int unsigned MAX_W     = 32,
  parameter int unsigned ITER_W    = 4
) (
  input  logic [ITER_W-1:0]          iter_i,
  output logic [NUM_ELEMS*MAX_W-1:0] vec_c_o
);

  for (genvar e = 0; e < int'(NUM_ELEMS); e++) begin : g_elem
    localparam logic [MAX_W-1:0] MASK = MAX_W'(slot_mask(e, MAX_W));
    logic [7:0] byte_c;

    // Pattern arithmetic wraps at 8 bits before being zero-extended into the lane.
    assign byte_c = 8'(iter_i) * PAT_ITER_MUL + 8'(e) * PAT_ELEM_MUL + PAT_OFFSET;
    assign vec_c_o[e*MAX_W +: MAX_W] = MAX_W'(byte_c) & MASK;
  end

endmodule

// File: rtl/mixed_vec_seq_checker.sv
// Drives NUM_ITERS pattern vectors out, checks the returned copies field-masked
// and reports done/pass/timeout/error status. Optional: MIXVEC_CHK_SIM_FINISH_EN.
module mixed_vec_seq_checker
  import mixed_vec_pkg::*;
#(
  parameter  int unsigned NUM_ELEMS   = 4,
  parameter  int unsigned MAX_W       = 32,
  parameter  int unsigned NUM_ITERS   = 16,
  parameter  int unsigned TIMEOUT     = 1024,
  localparam int unsigned ITER_W      = (NUM_ITERS > 1) ? $clog2(NUM_ITERS) : 1,
  localparam int unsigned ELEM_W      = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1,
  localparam int unsigned VEC_W       = NUM_ELEMS * MAX_W,
  localparam int unsigned ERR_FIRST_W = ITER_W + ELEM_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [VEC_W-1:0]       out_data_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [VEC_W-1:0]       in_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [ERR_CNT_W-1:0]   err_count_o,
  output logic [ERR_FIRST_W-1:0] err_first_o
);

  localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_ELEMS + 1);
  localparam int unsigned SUM_W = ERR_CNT_W + 1;
  localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(TIMEOUT - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(NUM_ITERS - 1);

  state_e                 state_q, state_d;
  logic [ITER_W-1:0]      iter_q, iter_d, iter_nxt_c;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [VEC_W-1:0]       out_data_q, out_data_d;
  logic [VEC_W-1:0]       in_data_q, in_data_d;
  logic [VEC_W-1:0]       send_vec_c, exp_vec_c;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   timeout_q, timeout_d;
  logic                   start_pend_q, start_pend_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [ERR_FIRST_W-1:0] err_first_q, err_first_d;
  logic [NUM_ELEMS-1:0]   mism_c;
  logic [CNT_W-1:0]       mism_cnt_c;
  logic [ELEM_W-1:0]      first_elem_c;
  logic [SUM_W-1:0]       err_sum_c;
  logic                   run_clear_c;
  logic                   out_hs_c, in_hs_c, wd_expired_c;

  assign out_hs_c     = out_valid_q & out_ready_i;
  assign in_hs_c      = in_ready_q & in_valid_i;
  assign wd_expired_c = (wd_q == WD_MAX);

  // SEND is only entered from IDLE/DONE (iteration 0) or from CHECK (next iteration).
  assign iter_nxt_c = (state_q == CHECK) ? iter_q + ITER_W'(1) : '0;

  mixed_vec_pattern_gen #(
    .NUM_ELEMS (NUM_ELEMS),
    .MAX_W     (MAX_W),
    .ITER_W    (ITER_W)
  ) u_gen_send (
    .iter_i  (iter_nxt_c),
    .vec_c_o (send_vec_c)
  );

  mixed_vec_pattern_gen #(
    .NUM_ELEMS (NUM_ELEMS),
    .MAX_W     (MAX_W),
    .ITER_W    (ITER_W)
  ) u_gen_exp (
    .iter_i  (iter_q),
    .vec_c_o (exp_vec_c)
  );

  for (genvar e = 0; e < int'(NUM_ELEMS); e++) begin : g_cmp
    localparam logic [MAX_W-1:0] MASK = MAX_W'(slot_mask(e, MAX_W));
    assign mism_c[e] = |((in_data_q[e*MAX_W +: MAX_W] ^ exp_vec_c[e*MAX_W +: MAX_W]) & MASK);
  end

  // Mismatch popcount and lowest mismatching element index.
  always_comb begin
    mism_cnt_c   = '0;
    first_elem_c = '0;
    for (int e = int'(NUM_ELEMS) - 1; e >= 0; e--) begin
      if (mism_c[e]) begin
        mism_cnt_c   = mism_cnt_c + CNT_W'(1);
        first_elem_c = ELEM_W'(e);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    wd_d         = wd_q;
    out_data_d   = out_data_q;
    in_data_d    = in_data_q;
    err_cnt_d    = err_cnt_q;
    err_first_d  = err_first_q;
    timeout_d    = timeout_q;
    done_d       = done_q;
    pass_d       = pass_q;
    start_pend_d = 1'b0;
    run_clear_c  = 1'b0;
    err_sum_c    = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = SEND;
          run_clear_c = 1'b1;
        end
      end
      SEND: begin
        if (out_hs_c) begin
          state_d = WAIT;
          wd_d    = '0;
        end else if (wd_expired_c) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      WAIT: begin
        if (in_hs_c) begin
          state_d   = CHECK;
          wd_d      = '0;
          in_data_d = in_data_i;
        end else if (wd_expired_c) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      CHECK: begin
        err_sum_c = {1'b0, err_cnt_q} + SUM_W'(mism_cnt_c);
        err_cnt_d = err_sum_c[ERR_CNT_W] ? '1 : err_sum_c[ERR_CNT_W-1:0];
        // A saturated count never returns to zero, so zero means no mismatch yet.
        if ((|mism_c) && (err_cnt_q == '0)) err_first_d = {iter_q, first_elem_c};
        if (iter_q == ITER_LAST) begin
          state_d = DONE;
        end else begin
          state_d = SEND;
          iter_d  = iter_q + ITER_W'(1);
        end
      end
      DONE: begin
        if (start_i || start_pend_q) begin
          state_d     = SEND;
          run_clear_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (run_clear_c) begin
      iter_d      = '0;
      wd_d        = '0;
      err_cnt_d   = '0;
      err_first_d = '0;
      timeout_d   = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
    end

    // A start arriving on the DONE-entry edge is remembered for one cycle.
    if ((state_d == DONE) && (state_q != DONE)) begin
      done_d       = 1'b1;
      pass_d       = (err_cnt_d == '0) && !timeout_d;
      start_pend_d = start_i;
    end

    if ((state_d == SEND) && (state_q != SEND)) out_data_d = send_vec_c;

    out_valid_d = (state_d == SEND);
    in_ready_d  = (state_d == WAIT);
    busy_d      = (state_d == SEND) || (state_d == WAIT) || (state_d == CHECK);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      iter_q       <= '0;
      wd_q         <= '0;
      out_data_q   <= '0;
      in_data_q    <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      start_pend_q <= 1'b0;
      err_cnt_q    <= '0;
      err_first_q  <= '0;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      wd_q         <= wd_d;
      out_data_q   <= out_data_d;
      in_data_q    <= in_data_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      start_pend_q <= start_pend_d;
      err_cnt_q    <= err_cnt_d;
      err_first_q  <= err_first_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign err_count_o = err_cnt_q;
  assign err_first_o = err_first_q;

`ifdef MIXVEC_CHK_SIM_FINISH_EN
`ifndef SYNTHESIS
  // Ends the simulation one cycle after the run completes.
  logic fin_pend_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fin_pend_q <= 1'b0;
    end else begin
      fin_pend_q <= (state_d == DONE) && (state_q != DONE);
      if ((state_d == DONE) && (state_q != DONE))
        $display("mixed_vec_seq_checker: iter=%0d err_count=%0d timeout=%0b",
                 iter_q, err_cnt_d, timeout_d);
      if (fin_pend_q) begin
        if (!pass_q) $fatal(1, "mixed_vec_seq_checker: run did not pass");
        else         $finish;
      end
    end
  end
`endif
`else
  // Without the simulation hook the block parks in DONE with its status held.
`endif

endmodule

// File: tb/tb_mixed_vec_seq_checker.sv
// Scoreboard bench for mixed_vec_seq_checker: a loopback return path with
// optional backpressure, corruption and junk upper bits; a monitor checks output.
module tb_mixed_vec_seq_checker;

  localparam int NE  = 4;
  localparam int MW  = 32;
  localparam int NI  = 16;
  localparam int TO  = 1024;
  localparam int VW  = NE * MW;
  localparam int EFW = 6;

  typedef struct packed {
    logic           pass;
    logic           timeout;
    logic [15:0]    err_count;
    logic [EFW-1:0] err_first;
  } res_t;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           start_i = 1'b0;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [VW-1:0]  out_data_o;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [VW-1:0]  in_data_i;
  logic           busy_o;
  logic           done_o;
  logic           pass_o;
  logic           timeout_o;
  logic [15:0]    err_count_o;
  logic [EFW-1:0] err_first_o;

  always #5 clk_i = ~clk_i;

  mixed_vec_seq_checker #(
    .NUM_ELEMS (NE),
    .MAX_W     (MW),
    .NUM_ITERS (NI),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .timeout_o   (timeout_o),
    .err_count_o (err_count_o),
    .err_first_o (err_first_o)
  );

  logic [VW-1:0] exp_out_q[$];
  res_t          exp_res_q[$];
  int            n_checks = 0;
  int            n_pass = 0;

  bit bp_en = 1'b0;
  bit corrupt_en = 1'b0;
  bit hi_en = 1'b0;
  bit hold_in = 1'b0;
  bit rdy_block = 1'b0;

  task automatic check(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    $display("FAIL %s: expected event did not happen", nm);
  endtask

  // Element i of iteration k: (k*0x9D + i*0x35 + 1) mod 256.
  // e.g. iter 0 -> 01 36 6b a0, iter 1 -> 9e d3 08 3d (element 0 first).
  function automatic logic [VW-1:0] pat_vec(input int k);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NE; i++) v[i*MW +: MW] = 32'((k * 157 + i * 53 + 1) % 256);
    return v;
  endfunction

  task automatic push_run(input int n_vec, input logic p, input logic t,
                          input int ec, input int ef, input bit with_res);
    res_t r;
    for (int k = 0; k < n_vec; k++) exp_out_q.push_back(pat_vec(k));
    if (with_res) begin
      r.pass      = p;
      r.timeout   = t;
      r.err_count = 16'(ec);
      r.err_first = EFW'(ef);
      exp_res_q.push_back(r);
    end
  endtask

  // Return path: one-deep loopback buffer, driven on the falling edge.
  initial begin
    logic [VW-1:0] lb_data;
    bit            lb_full;
    int            cap_idx;
    lb_data = '0;
    lb_full = 1'b0;
    cap_idx = 0;
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni || !busy_o) begin
        lb_full = 1'b0;
        cap_idx = 0;
      end
      if (lb_full && !hold_in && (!bp_en || $urandom_range(0, 1) == 1)) begin
        in_valid_i = 1'b1;
        in_data_i  = lb_data;
      end else begin
        in_valid_i = 1'b0;
        in_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (in_valid_i && in_ready_o) lb_full = 1'b0;
      out_ready_i = rdy_block ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
      if (out_valid_o && out_ready_i) begin
        lb_data = out_data_o;
        if (corrupt_en && cap_idx == 5) lb_data[1*MW + 3] = ~lb_data[1*MW + 3];
        if (hi_en) begin
          lb_data[31:8]  = '1;
          lb_data[63:48] = '1;
          lb_data[95:88] = '1;
        end
        lb_full = 1'b1;
        cap_idx++;
      end
    end
  end

  // Monitor: compares every accepted vector and every run result.
  initial begin
    logic [VW-1:0] prev_data;
    bit            prev_stall;
    bit            prev_done;
    logic [VW-1:0] e;
    res_t          r;
    prev_data  = '0;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_ni) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall && out_valid_o) check("out_stable", out_data_o, prev_data);
        if (out_valid_o && out_ready_i) begin
          if (exp_out_q.size() == 0) fail_now("out_unexpected");
          else begin
            e = exp_out_q.pop_front();
            check("out_data", out_data_o, e);
          end
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_data  = out_data_o;
        if (done_o && !prev_done) begin
          if (exp_res_q.size() == 0) fail_now("done_unexpected");
          else begin
            r = exp_res_q.pop_front();
            check("pass", VW'(pass_o), VW'(r.pass));
            check("timeout", VW'(timeout_o), VW'(r.timeout));
            check("err_count", VW'(err_count_o), VW'(r.err_count));
            check("err_first", VW'(err_first_o), VW'(r.err_first));
          end
        end
        prev_done = done_o;
      end
    end
  end

  task automatic run_and_wait(input string nm, input int bound, output int cycles, output int sends);
    cycles = 0;
    sends  = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    do begin
      @(negedge clk_i);
      start_i = 1'b0;
      cycles++;
      if (out_valid_o) sends++;
    end while (!done_o && cycles < bound);
    if (!done_o) fail_now(nm);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, VW'({out_valid_o, in_ready_o, busy_o, done_o, pass_o, timeout_o,
                   err_count_o, err_first_o}), '0);
    check({nm, "_data"}, out_data_o, '0);
  endtask

  initial begin
    int cycles;
    int sends;
    int cnt;

    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Plain loopback: 3 cycles per iteration plus the start edge.
    push_run(NI, 1'b1, 1'b0, 0, 0, 1'b1);
    run_and_wait("done_loopback", 200, cycles, sends);
    check("latency", VW'(cycles), VW'(3 * NI + 1));

    // Random backpressure on both handshakes.
    bp_en = 1'b1;
    push_run(NI, 1'b1, 1'b0, 0, 0, 1'b1);
    run_and_wait("done_backpressure", 3000, cycles, sends);
    bp_en = 1'b0;

    // Bit 3 of element 1 flipped on iteration 5: first mismatch {5,1}.
    corrupt_en = 1'b1;
    push_run(NI, 1'b0, 1'b0, 1, (5 << 2) | 1, 1'b1);
    run_and_wait("done_corrupt", 200, cycles, sends);
    corrupt_en = 1'b0;

    // Junk above each element width must be ignored.
    hi_en = 1'b1;
    push_run(NI, 1'b1, 1'b0, 0, 0, 1'b1);
    run_and_wait("done_high_bits", 200, cycles, sends);
    hi_en = 1'b0;

    // Consumer never ready: watchdog ends the run after TIMEOUT cycles in SEND.
    rdy_block = 1'b1;
    push_run(0, 1'b0, 1'b1, 0, 0, 1'b1);
    run_and_wait("done_timeout", 2000, cycles, sends);
    check("timeout_send_cycles", VW'(sends), VW'(TO));
    rdy_block = 1'b0;

    // Reset while waiting for the returned vector, then a fresh run.
    hold_in = 1'b1;
    push_run(1, 1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cnt = 0;
    while (!in_ready_o && cnt < 20) begin
      @(negedge clk_i);
      cnt++;
    end
    if (!in_ready_o) fail_now("reach_wait");
    rst_ni = 1'b0;
    #2;
    check_all_zero("reset_mid_wait");
    check("abort_drain", VW'(exp_out_q.size()), '0);
    @(negedge clk_i);
    hold_in = 1'b0;
    rst_ni  = 1'b1;
    @(negedge clk_i);
    push_run(NI, 1'b1, 1'b0, 0, 0, 1'b1);
    run_and_wait("done_after_reset", 200, cycles, sends);
    check("latency_after_reset", VW'(cycles), VW'(3 * NI + 1));

    check("sb_out_drain", VW'(exp_out_q.size()), '0);
    check("sb_res_drain", VW'(exp_res_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "global timeout");
  end

endmodule
